latency_stats: RTL and testbench
================================

Name: latency_stats

Overview:
- Consumes the free-running 32-bit count from the link latency timer and the stop event that ends each measured interval.
- Takes a snapshot of the count on each (delayed) stop event and derives the per-interval latency as the difference from the previous snapshot.
- Accumulates last/min/max/sum over a programmed number of samples, then flags done for readout by the GLIB register interface.

Parameters:
- NUM_SAMPLES, 1000: samples per run; legal range 1..65535.
- SNAP_DELAY, 2: cycles from stop_evt to count snapshot, covering the timer's two-register lag; legal 0..7.
- SUM_W, 48: width of the sum accumulator.
- TIMEOUT_CYCLES, 1000000: watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; 0 resets the block on the next clk edge
- arm  in  1  single-cycle pulse; clears stats, takes the baseline snapshot, starts a run
- clear  in  1  single-cycle pulse; clears all stats and returns to IDLE
- stop_evt  in  1  stop strobe; the same signal that drives the timer's stop input
- timer_count  in  32  free-running timer count
- busy  out  1  1 while in ACCUM
- done  out  1  1 while in DONE
- sample_cnt  out  16  accepted samples this run
- last_lat  out  32  most recent latency
- min_lat  out  32  minimum latency
- max_lat  out  32  maximum latency
- sum_lat  out  SUM_W  saturating sum of latencies
- sum_ovf  out  1  sticky; sum_lat has saturated
- timeout  out  1  sticky watchdog flag; tied to 0 when the optional feature is off

Behaviour:
- States: IDLE, ACCUM, DONE. Reset state is IDLE.
- Reset values: all outputs 0, except min_lat = 32'hFFFFFFFF. Baseline register = 0. Delay line is cleared.
- stop_evt delay line: SNAP_DELAY stages. The event that emerges from the last stage is the capture event "cap". With SNAP_DELAY=0, cap = stop_evt in the same cycle.
- IDLE or DONE, on arm:
  - baseline <= timer_count; stats cleared to reset values; delay line flushed; next state ACCUM.
- ACCUM, on cap:
  - lat = timer_count - baseline, computed modulo 2^32 so timer wrap gives the correct value.
  - baseline <= timer_count.
  - last_lat <= lat; min_lat / max_lat updated by unsigned compare; sample_cnt += 1.
  - sum_lat += lat, saturating at all-ones; sum_ovf set when saturation occurs.
  - A lat of 0 is a valid sample.
- ACCUM -> DONE: on the cap that makes sample_cnt equal NUM_SAMPLES. All stats are already updated in the cycle done rises.
- Latency: cap in cycle N -> updated stats and sample_cnt visible from cycle N+1.
- cap in IDLE or DONE is ignored; stats stay frozen.
- arm during ACCUM restarts the run: same actions as arm from IDLE.
- arm and cap in the same cycle: arm wins and the sample is dropped.
- clear in any state: stats go to reset values, delay line is flushed, next state IDLE.
- clear and arm in the same cycle: clear wins.
- reset asserted mid-run: identical to power-on reset; no partial stats are kept.
- stop_evt held high for k cycles produces k captures. The upstream stop strobe is a single-cycle pulse.

Optional Feature:
- Macro LATENCY_STATS_TIMEOUT_EN.
- Defined:
  - 32-bit watchdog counter, cleared on arm and on every accepted cap.
  - Increments each cycle in ACCUM.
  - On reaching TIMEOUT_CYCLES: timeout <= 1 (sticky until arm, clear or reset), next state DONE with partial stats.
  - A cap that arrives in the same cycle as the timeout is accepted, and the timeout still fires.
- Undefined: no watchdog logic; timeout is constant 0; ACCUM exits only via the sample count, arm, clear or reset.

Test Plan:
- Reset 0 for 2 cycles -> all outputs 0, min_lat = FFFFFFFF, busy=0, done=0; any stop_evt is ignored.
- NUM_SAMPLES=3, SNAP_DELAY=0:
  - stimulus: arm at count 100; caps at counts 150, 170, 270.
  - response: last_lat = 100, min_lat = 20, max_lat = 100, sum_lat = 170, sample_cnt = 3.
  - done rises the cycle after the third cap; busy falls in the same cycle.
- Wrap-around: baseline FFFFFFF0, cap at 00000010 -> last_lat = 0x20.
- arm and cap in the same cycle during ACCUM -> sample_cnt = 0, baseline = current timer_count.
- clear and arm in the same cycle -> state IDLE.
- SUM_W=33, two samples of FFFFFFFF each -> sum_lat = 1_FFFFFFFE, sum_ovf = 0. A third sample of 2 -> sum_lat = all-ones, sum_ovf = 1.
- With LATENCY_STATS_TIMEOUT_EN, TIMEOUT_CYCLES=50, arm and no stop_evt -> done and timeout both rise on cycle 50 after arm, sample_cnt = 0. Without the macro, the same stimulus leaves busy=1 indefinitely.

Source files
------------

// File: rtl/latency_stats_if.sv
// rtl/latency_stats_if.sv - control, timer and statistics bundle for latency_stats
interface latency_stats_if #(
   parameter int SUM_W = 48
);
   logic             arm;
   logic             clear;
   logic             stop_evt;
   logic [31:0]      timer_count;
   logic             busy;
   logic             done;
   logic [15:0]      sample_cnt;
   logic [31:0]      last_lat;
   logic [31:0]      min_lat;
   logic [31:0]      max_lat;
   logic [SUM_W-1:0] sum_lat;
   logic             sum_ovf;
   logic             timeout;

   modport master (
      output arm, clear, stop_evt, timer_count,
      input  busy, done, sample_cnt, last_lat, min_lat, max_lat, sum_lat, sum_ovf, timeout
   );

   modport slave (
      input  arm, clear, stop_evt, timer_count,
      output busy, done, sample_cnt, last_lat, min_lat, max_lat, sum_lat, sum_ovf, timeout
   );
endinterface

// File: rtl/latency_stats.sv
// rtl/latency_stats.sv - per-interval latency last/min/max/saturating-sum statistics
// Optional watchdog enabled by defining LATENCY_STATS_TIMEOUT_EN.
module latency_stats #(
   parameter int NUM_SAMPLES    = 1000,
   parameter int SNAP_DELAY     = 2,
   parameter int SUM_W          = 48,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   latency_stats_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam int          DW  = (SNAP_DELAY == 0) ? 1 : SNAP_DELAY;
   localparam int          SW1 = SUM_W + 1;
   localparam logic [15:0] NS  = 16'(NUM_SAMPLES);

   state_t           state_q, state_d;
   logic [DW-1:0]    dly_q, dly_d;
   logic [31:0]      base_q, base_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [31:0]      last_q, last_d;
   logic [31:0]      min_q, min_d;
   logic [31:0]      max_q, max_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             cap;
   logic [31:0]      lat;
   logic [SUM_W:0]   sum_ext;
`ifdef LATENCY_STATS_TIMEOUT_EN
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);
   logic [31:0]      wd_q, wd_d;
   logic             to_q, to_d;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      min_d   = min_q;
      max_d   = max_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      dly_d   = DW'({dly_q, bus.stop_evt});
      // Capture fires when the stop strobe emerges from the lag-matching delay line.
      cap     = (SNAP_DELAY == 0) ? bus.stop_evt : dly_q[DW-1];
      lat     = bus.timer_count - base_q;
      sum_ext = {1'b0, sum_q} + SW1'(lat);
`ifdef LATENCY_STATS_TIMEOUT_EN
      wd_d = wd_q;
      to_d = to_q;
`endif
      if (bus.clear || bus.arm) begin
         cnt_d   = '0;
         last_d  = '0;
         min_d   = '1;
         max_d   = '0;
         sum_d   = '0;
         ovf_d   = 1'b0;
         dly_d   = '0;
         state_d = bus.clear ? IDLE : ACCUM;
         if (!bus.clear) base_d = bus.timer_count;
`ifdef LATENCY_STATS_TIMEOUT_EN
         wd_d = '0;
         to_d = 1'b0;
`endif
      end else if (state_q == ACCUM) begin
         if (cap) begin
            base_d = bus.timer_count;
            last_d = lat;
            cnt_d  = cnt_q + 16'd1;
            if (lat < min_q) min_d = lat;
            if (lat > max_q) max_d = lat;
            if (sum_ext[SUM_W]) begin
               sum_d = '1;
               ovf_d = 1'b1;
            end else begin
               sum_d = sum_ext[SUM_W-1:0];
            end
            if (cnt_q + 16'd1 == NS) state_d = DONE;
         end
`ifdef LATENCY_STATS_TIMEOUT_EN
         // A cap in the expiry cycle is kept, but the watchdog still ends the run.
         wd_d = cap ? '0 : wd_q + 32'd1;
         if (wd_q + 32'd1 == TO_LIM) begin
            to_d    = 1'b1;
            state_d = DONE;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         dly_q   <= '0;
         base_q  <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         min_q   <= '1;
         max_q   <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
`ifdef LATENCY_STATS_TIMEOUT_EN
         wd_q    <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         min_q   <= min_d;
         max_q   <= max_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
`ifdef LATENCY_STATS_TIMEOUT_EN
         wd_q    <= wd_d;
         to_q    <= to_d;
`endif
      end
   end

   assign bus.busy       = (state_q == ACCUM);
   assign bus.done       = (state_q == DONE);
   assign bus.sample_cnt = cnt_q;
   assign bus.last_lat   = last_q;
   assign bus.min_lat    = min_q;
   assign bus.max_lat    = max_q;
   assign bus.sum_lat    = sum_q;
   assign bus.sum_ovf    = ovf_q;
`ifdef LATENCY_STATS_TIMEOUT_EN
   assign bus.timeout    = to_q;
`else
   assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_latency_stats.sv
// tb/tb_latency_stats.sv - scoreboard bench for latency_stats (two configurations)
module tb_latency_stats;
   typedef struct packed {
      logic        busy;
      logic        done;
      logic [15:0] cnt;
      logic [31:0] last;
      logic [31:0] min;
      logic [31:0] max;
      logic [47:0] sum;
      logic        ovf;
      logic        to;
   } stats_t;

   typedef struct {
      int     cyc;
      bit     d;
      string  name;
      stats_t v;
   } sb_t;

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   sb_t    sbq[$];
   sb_t    ment;
   stats_t mact;

   latency_stats_if #(.SUM_W(48)) ifa ();
   latency_stats_if #(.SUM_W(33)) ifb ();

   latency_stats #(.NUM_SAMPLES(3), .SNAP_DELAY(0), .SUM_W(48), .TIMEOUT_CYCLES(50)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa));
   latency_stats #(.NUM_SAMPLES(3), .SNAP_DELAY(2), .SUM_W(33), .TIMEOUT_CYCLES(50)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic stats_t snap(input bit d);
      stats_t s;
      if (!d) s = {ifa.busy, ifa.done, ifa.sample_cnt, ifa.last_lat, ifa.min_lat,
                   ifa.max_lat, ifa.sum_lat, ifa.sum_ovf, ifa.timeout};
      else    s = {ifb.busy, ifb.done, ifb.sample_cnt, ifb.last_lat, ifb.min_lat,
                   ifb.max_lat, 15'd0, ifb.sum_lat, ifb.sum_ovf, ifb.timeout};
      return s;
   endfunction

   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         ment = sbq.pop_front();
         mact = snap(ment.d);
         checks++;
         if (ment.cyc != cyc || mact !== ment.v) begin
            errors++;
            $display("FAIL %s (cyc %0d): got busy=%0b done=%0b cnt=%0d last=%h min=%h max=%h sum=%h ovf=%0b to=%0b; want busy=%0b done=%0b cnt=%0d last=%h min=%h max=%h sum=%h ovf=%0b to=%0b",
                     ment.name, cyc, mact.busy, mact.done, mact.cnt, mact.last, mact.min, mact.max,
                     mact.sum, mact.ovf, mact.to, ment.v.busy, ment.v.done, ment.v.cnt, ment.v.last,
                     ment.v.min, ment.v.max, ment.v.sum, ment.v.ovf, ment.v.to);
         end
      end
   end

   // Expected state after the next clock edge.
   task automatic exp_push(input bit d, input string name, input logic busy, input logic done,
                           input logic [15:0] cnt, input logic [31:0] last, input logic [31:0] mn,
                           input logic [31:0] mx, input logic [47:0] sum, input logic ovf,
                           input logic to);
      sb_t e;
      e.cyc  = cyc + 1;
      e.d    = d;
      e.name = name;
      e.v    = {busy, done, cnt, last, mn, mx, sum, ovf, to};
      sbq.push_back(e);
   endtask

   task automatic exp_rst(input bit d, input string name, input logic busy, input logic done,
                          input logic to);
      exp_push(d, name, busy, done, 16'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 48'd0, 1'b0, to);
   endtask

   task automatic tick(input bit d, input bit a, input bit c, input bit s, input logic [31:0] t);
      if (!d) begin
         ifa.arm = a; ifa.clear = c; ifa.stop_evt = s; ifa.timer_count = t;
      end else begin
         ifb.arm = a; ifb.clear = c; ifb.stop_evt = s; ifb.timer_count = t;
      end
      @(posedge clk); #1;
      ifa.arm = 1'b0; ifa.clear = 1'b0; ifa.stop_evt = 1'b0;
      ifb.arm = 1'b0; ifb.clear = 1'b0; ifb.stop_evt = 1'b0;
   endtask

   initial begin
      ifa.arm = 1'b0; ifa.clear = 1'b0; ifa.stop_evt = 1'b1; ifa.timer_count = 32'd7;
      ifb.arm = 1'b0; ifb.clear = 1'b0; ifb.stop_evt = 1'b1; ifb.timer_count = 32'd7;
      @(posedge clk); #1;
      exp_rst(0, "reset_a", 0, 0, 0);
      exp_rst(1, "reset_b", 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      ifa.stop_evt = 1'b0; ifb.stop_evt = 1'b0;

      // Configuration A: 3 samples, no snapshot delay, 48-bit sum.
      exp_rst(0, "idle_stop_ignored", 0, 0, 0);             tick(0, 0, 0, 1, 32'd5);
      exp_rst(0, "arm_at_100", 1, 0, 0);                    tick(0, 1, 0, 0, 32'd100);
      tick(0, 0, 0, 0, 32'd120);
      exp_push(0, "cap_150", 1, 0, 1, 50, 50, 50, 50, 0, 0);     tick(0, 0, 0, 1, 32'd150);
      exp_push(0, "cap_170", 1, 0, 2, 20, 20, 50, 70, 0, 0);     tick(0, 0, 0, 1, 32'd170);
      exp_push(0, "cap_270_done", 0, 1, 3, 100, 20, 100, 170, 0, 0); tick(0, 0, 0, 1, 32'd270);
      exp_push(0, "done_frozen", 0, 1, 3, 100, 20, 100, 170, 0, 0);  tick(0, 0, 0, 1, 32'd300);
      exp_rst(0, "arm_wrap", 1, 0, 0);                      tick(0, 1, 0, 0, 32'hFFFFFFF0);
      exp_push(0, "cap_wrap", 1, 0, 1, 32'h20, 32'h20, 32'h20, 48'h20, 0, 0);
      tick(0, 0, 0, 1, 32'h00000010);
      exp_rst(0, "arm_and_cap", 1, 0, 0);                   tick(0, 1, 0, 1, 32'd500);
      exp_push(0, "cap_after_rearm", 1, 0, 1, 30, 30, 30, 30, 0, 0); tick(0, 0, 0, 1, 32'd530);
      exp_push(0, "zero_latency", 1, 0, 2, 0, 0, 30, 30, 0, 0);      tick(0, 0, 0, 1, 32'd530);
      exp_rst(0, "clear_and_arm", 0, 0, 0);                 tick(0, 1, 1, 0, 32'd600);
      exp_rst(0, "idle_after_clear", 0, 0, 0);              tick(0, 0, 0, 1, 32'd610);

      // Configuration B: 2-cycle snapshot delay, 33-bit saturating sum.
      exp_rst(1, "b_arm", 1, 0, 0);                         tick(1, 1, 0, 0, 32'd0);
      exp_rst(1, "b_delay_1", 1, 0, 0);                     tick(1, 0, 0, 1, 32'd10);
      exp_rst(1, "b_delay_2", 1, 0, 0);                     tick(1, 0, 0, 0, 32'd11);
      exp_push(1, "b_sample1", 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               48'h0_FFFFFFFF, 0, 0);                       tick(1, 0, 0, 0, 32'hFFFFFFFF);
      tick(1, 0, 0, 1, 32'd5);
      tick(1, 0, 0, 0, 32'd6);
      exp_push(1, "b_sample2", 1, 0, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               48'h1_FFFFFFFE, 0, 0);                       tick(1, 0, 0, 0, 32'hFFFFFFFE);
      tick(1, 0, 0, 1, 32'd1);
      tick(1, 0, 0, 0, 32'd2);
      exp_push(1, "b_saturate", 0, 1, 3, 32'd2, 32'd2, 32'hFFFFFFFF,
               48'h1_FFFFFFFF, 1, 0);                       tick(1, 0, 0, 0, 32'd0);
      tick(1, 0, 0, 1, 32'd40);
      exp_rst(1, "b_arm_flush", 1, 0, 0);                   tick(1, 1, 0, 0, 32'd50);
      exp_rst(1, "b_flushed", 1, 0, 0);                     tick(1, 0, 0, 0, 32'd60);
      exp_rst(1, "b_flushed2", 1, 0, 0);                    tick(1, 0, 0, 0, 32'd70);

      // Mid-run reset drops partial statistics on both instances.
      exp_rst(0, "arm_2000", 1, 0, 0);                      tick(0, 1, 0, 0, 32'd2000);
      exp_push(0, "cap_2010", 1, 0, 1, 10, 10, 10, 10, 0, 0);    tick(0, 0, 0, 1, 32'd2010);
      reset = 1'b0;
      exp_rst(0, "midrun_reset_a", 0, 0, 0);
      exp_rst(1, "midrun_reset_b", 0, 0, 0);
      tick(0, 0, 0, 0, 32'd2020);
      reset = 1'b1;

      // Watchdog: arm with no stop events for 50 cycles.
      exp_rst(0, "wd_arm", 1, 0, 0);                        tick(0, 1, 0, 0, 32'd3000);
      for (int k = 1; k <= 50; k++) begin
         if (k == 49) exp_rst(0, "wd_cycle49", 1, 0, 0);
         if (k == 50) begin
`ifdef LATENCY_STATS_TIMEOUT_EN
            exp_rst(0, "wd_cycle50", 0, 1, 1);
`else
            exp_rst(0, "wd_cycle50", 1, 0, 0);
`endif
         end
         tick(0, 0, 0, 0, 32'd3000 + 32'(k));
      end
      exp_rst(0, "wd_after", 0, 0, 0);                      tick(0, 0, 1, 0, 32'd3100);

      for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
      @(negedge clk); #1;
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
